// File: rtl/seq_alu_if.sv
// Handshake bundle between the issuing controller and seq_alu.
// The controller is the master; the ALU is the slave.
interface seq_alu_if #(
    parameter int WIDTH = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_cmd;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rslt;
    logic             flag;

    modport master (
        output in_valid, alu_cmd, inA, inB, out_ready,
        input  in_ready, out_valid, rslt, flag
    );

    modport slave (
        input  in_valid, alu_cmd, inA, inB, out_ready,
        output in_ready, out_valid, rslt, flag
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready on both sides: single-cycle arithmetic/logic,
// bit-serial variable shifts and a shift-add multiply, with registered result and flag.
module seq_alu #(
    parameter int WIDTH = 9
) (
    input logic      clk,
    input logic      rst_n,
    seq_alu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_MAX   = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_LSL = 3'b001,
        OP_MUL = 3'b010,
        OP_XOR = 3'b011,
        OP_AND = 3'b100,
        OP_LSR = 3'b101,
        OP_SUB = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    state_e             state_q;
    op_e                op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] a_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rslt_q;
    logic               flag_q;
    logic               in_ready_q;
    logic               out_valid_q;

    op_e                cmd;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [CNT_W-1:0]   k_d;
    logic [WIDTH-1:0]   rslt_d;
    logic               flag_d;
    logic [2*WIDTH-1:0] a_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   b_d;
    logic [WIDTH-1:0]   fin_rslt_d;
    logic               fin_flag_d;

    assign cmd     = op_e'(bus.alu_cmd);
    assign add_ext = {1'b0, bus.inA} + {1'b0, bus.inB};
    assign sub_ext = {1'b0, bus.inA} - {1'b0, bus.inB};

    // Accept-time decode: immediate result for single-cycle ops, iteration count otherwise.
    always_comb begin
        rslt_d = bus.inA;
        flag_d = 1'b0;
        k_d    = '0;
        case (cmd)
            OP_ADD: begin
                rslt_d = add_ext[WIDTH-1:0];
                flag_d = add_ext[WIDTH];
            end
            OP_LSL, OP_LSR: k_d = (bus.inB > W_MAX) ? CNT_MAX : bus.inB[CNT_W-1:0];
            OP_MUL:         k_d = CNT_MAX;
            OP_XOR:         rslt_d = bus.inA ^ bus.inB;
            OP_AND:         rslt_d = bus.inA & bus.inB;
            OP_SUB: begin
                rslt_d = sub_ext[WIDTH-1:0];
                flag_d = sub_ext[WIDTH];
            end
            OP_CMP: begin
                rslt_d = sub_ext[WIDTH-1:0];
                flag_d = (bus.inA == bus.inB);
            end
            default: ;
        endcase
    end

    // One iteration: a_q doubles as shift register and multiplicand, b_q as multiplier.
    always_comb begin
        a_d   = (op_q == OP_LSR) ? (a_q >> 1) : (a_q << 1);
        b_d   = b_q >> 1;
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        if (op_q == OP_MUL) begin
            fin_rslt_d = acc_d[WIDTH-1:0];
            fin_flag_d = |acc_d[2*WIDTH-1:WIDTH];
        end else begin
            fin_rslt_d = a_d[WIDTH-1:0];
            fin_flag_d = (op_q == OP_LSR) ? a_q[0] : a_q[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            cnt_q       <= '0;
            a_q         <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            rslt_q      <= '0;
            flag_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op_q       <= cmd;
                        a_q        <= {{WIDTH{1'b0}}, bus.inA};
                        b_q        <= bus.inB;
                        acc_q      <= '0;
                        cnt_q      <= k_d;
                        in_ready_q <= 1'b0;
                        if (k_d != '0) begin
                            state_q <= S_BUSY;
                        end else begin
                            rslt_q      <= rslt_d;
                            flag_q      <= flag_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        rslt_q      <= fin_rslt_d;
                        flag_q      <= fin_flag_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.rslt      = rslt_q;
    assign bus.flag      = flag_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH 9, 4 and 16 with hand-computed expectations.
module tb_seq_alu;
    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_LSL = 3'b001;
    localparam logic [2:0] C_MUL = 3'b010;
    localparam logic [2:0] C_XOR = 3'b011;
    localparam logic [2:0] C_AND = 3'b100;
    localparam logic [2:0] C_LSR = 3'b101;
    localparam logic [2:0] C_SUB = 3'b110;
    localparam logic [2:0] C_CMP = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  iv = '0;
    logic [2:0]  cmd = '0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        out_ready = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(9))  if9 ();
    seq_alu_if #(.WIDTH(4))  if4 ();
    seq_alu_if #(.WIDTH(16)) if16 ();

    assign if9.in_valid   = iv[0];
    assign if9.alu_cmd    = cmd;
    assign if9.inA        = a32[8:0];
    assign if9.inB        = b32[8:0];
    assign if9.out_ready  = out_ready;
    assign if4.in_valid   = iv[1];
    assign if4.alu_cmd    = cmd;
    assign if4.inA        = a32[3:0];
    assign if4.inB        = b32[3:0];
    assign if4.out_ready  = out_ready;
    assign if16.in_valid  = iv[2];
    assign if16.alu_cmd   = cmd;
    assign if16.inA       = a32[15:0];
    assign if16.inB       = b32[15:0];
    assign if16.out_ready = out_ready;

    seq_alu #(.WIDTH(9))  u_alu9  (.clk(clk), .rst_n(rst_n), .bus(if9));
    seq_alu #(.WIDTH(4))  u_alu4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    seq_alu #(.WIDTH(16)) u_alu16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    function automatic logic get_ov(input int inst);
        case (inst)
            0:       return if9.out_valid;
            1:       return if4.out_valid;
            default: return if16.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int inst);
        case (inst)
            0:       return if9.in_ready;
            1:       return if4.in_ready;
            default: return if16.in_ready;
        endcase
    endfunction

    function automatic logic get_f(input int inst);
        case (inst)
            0:       return if9.flag;
            1:       return if4.flag;
            default: return if16.flag;
        endcase
    endfunction

    function automatic logic [31:0] get_r(input int inst);
        case (inst)
            0:       return 32'(if9.rslt);
            1:       return 32'(if4.rslt);
            default: return 32'(if16.rslt);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency counts clock edges from the accept edge up to the first cycle with out_valid high.
    task automatic run_op(input int inst, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic f, output int lat);
        @(negedge clk);
        check("pre_in_ready", 32'(get_ir(inst)), 1);
        cmd       = c;
        a32       = a;
        b32       = b;
        iv[inst]  = 1'b1;
        lat       = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            iv[inst] = 1'b0;
        end while (!get_ov(inst) && lat < 64);
        r = get_r(inst);
        f = get_f(inst);
    endtask

    task automatic run_chk(input string tag, input int inst, input logic [2:0] c,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r_exp, input logic f_exp, input int lat_exp);
        logic [31:0] r;
        logic        f;
        int          lat;
        run_op(inst, c, a, b, r, f, lat);
        check({tag, ".valid"}, 32'(get_ov(inst)), 1);
        check({tag, ".rslt"}, r, r_exp);
        check({tag, ".flag"}, 32'(f), 32'(f_exp));
        check({tag, ".lat"}, lat, lat_exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".idle"}, 32'({get_ov(inst), get_ir(inst)}), 32'b01);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst.in_ready", 32'(get_ir(0)), 1);
        check("rst.out_valid", 32'(get_ov(0)), 0);
        check("rst.rslt", get_r(0), 0);
        check("rst.flag", 32'(get_f(0)), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_chk("add_wrap",   0, C_ADD, 32'h1FF, 32'h001, 32'h000, 1'b1, 1);
        run_chk("add_plain",  0, C_ADD, 32'h0F0, 32'h00F, 32'h0FF, 1'b0, 1);
        run_chk("sub_borrow", 0, C_SUB, 32'h003, 32'h005, 32'h1FE, 1'b1, 1);
        run_chk("sub_plain",  0, C_SUB, 32'h005, 32'h003, 32'h002, 1'b0, 1);
        run_chk("cmp_eq",     0, C_CMP, 32'h0AA, 32'h0AA, 32'h000, 1'b1, 1);
        run_chk("cmp_ne",     0, C_CMP, 32'h005, 32'h003, 32'h002, 1'b0, 1);
        run_chk("xor",        0, C_XOR, 32'h155, 32'h0FF, 32'h1AA, 1'b0, 1);
        run_chk("and",        0, C_AND, 32'h155, 32'h0F0, 32'h050, 1'b0, 1);
        run_chk("lsl_1",      0, C_LSL, 32'h101, 32'h001, 32'h002, 1'b1, 2);
        run_chk("lsr_2",      0, C_LSR, 32'h003, 32'h002, 32'h000, 1'b1, 3);
        run_chk("lsl_0",      0, C_LSL, 32'h0B5, 32'h000, 32'h0B5, 1'b0, 1);
        run_chk("lsl_20",     0, C_LSL, 32'h0B5, 32'd20,  32'h000, 1'b1, 10);
        run_chk("lsl_w",      0, C_LSL, 32'h1FF, 32'd9,   32'h000, 1'b1, 10);
        run_chk("lsr_w",      0, C_LSR, 32'h100, 32'd9,   32'h000, 1'b1, 10);
        run_chk("mul_small",  0, C_MUL, 32'd12,  32'd13,  32'd156, 1'b0, 10);
        run_chk("mul_ovf",    0, C_MUL, 32'h100, 32'h002, 32'h000, 1'b1, 10);
        run_chk("mul_zero",   0, C_MUL, 32'h000, 32'h1AB, 32'h000, 1'b0, 10);
        run_chk("mul_max",    0, C_MUL, 32'h1FF, 32'h1FF, 32'h001, 1'b1, 10);

        run_chk("w4.add",     1, C_ADD, 32'hF, 32'h3, 32'h2, 1'b1, 1);
        run_chk("w4.lsr1",    1, C_LSR, 32'hA, 32'h1, 32'h5, 1'b0, 2);
        run_chk("w4.lsr3",    1, C_LSR, 32'hF, 32'h3, 32'h1, 1'b1, 4);
        run_chk("w4.lsr_big", 1, C_LSR, 32'h8, 32'h7, 32'h0, 1'b1, 5);
        run_chk("w4.mul_ovf", 1, C_MUL, 32'h7, 32'h5, 32'h3, 1'b1, 5);
        run_chk("w4.mul_fit", 1, C_MUL, 32'h3, 32'h5, 32'hF, 1'b0, 5);

        run_chk("w16.add_c",  2, C_ADD, 32'hFFFF, 32'h0002, 32'h0001, 1'b1, 1);
        run_chk("w16.add",    2, C_ADD, 32'h1234, 32'h4321, 32'h5555, 1'b0, 1);
        run_chk("w16.lsr15",  2, C_LSR, 32'h8000, 32'd15,   32'h0001, 1'b0, 16);
        run_chk("w16.lsr4",   2, C_LSR, 32'hC3A5, 32'd4,    32'h0C3A, 1'b0, 5);
        run_chk("w16.mul",    2, C_MUL, 32'd300,  32'd200,  32'hEA60, 1'b0, 17);
        run_chk("w16.mul_o",  2, C_MUL, 32'h0100, 32'h0100, 32'h0000, 1'b1, 17);
        run_chk("w16.mul_mx", 2, C_MUL, 32'hFFFF, 32'hFFFF, 32'h0001, 1'b1, 17);

        // Backpressure: result held in DONE while inputs churn, then reissue right after release.
        @(negedge clk);
        cmd = C_XOR; a32 = 32'h155; b32 = 32'h0FF; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        check("bp.valid0", 32'(get_ov(0)), 1);
        check("bp.rslt0", get_r(0), 32'h1AA);
        for (int i = 0; i < 5; i++) begin
            iv[0] = ~iv[0];
            cmd   = (i % 2 == 0) ? C_ADD : C_MUL;
            a32   = $urandom;
            b32   = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("bp.hold_valid", 32'(get_ov(0)), 1);
            check("bp.hold_ready", 32'(get_ir(0)), 0);
            check("bp.hold_rslt", get_r(0), 32'h1AA);
            check("bp.hold_flag", 32'(get_f(0)), 0);
        end
        cmd = C_AND; a32 = 32'h155; b32 = 32'h0F0; iv[0] = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp.rel_valid", 32'(get_ov(0)), 0);
        check("bp.rel_ready", 32'(get_ir(0)), 1);
        check("bp.rel_rslt", get_r(0), 32'h1AA);
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        check("bp.new_valid", 32'(get_ov(0)), 1);
        check("bp.new_rslt", get_r(0), 32'h050);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a multiply must abort it without ever presenting a result.
        @(negedge clk);
        cmd = C_MUL; a32 = 32'd12; b32 = 32'd13; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.in_ready", 32'(get_ir(0)), 1);
        check("abort.out_valid", 32'(get_ov(0)), 0);
        check("abort.rslt", get_r(0), 0);
        check("abort.flag", 32'(get_f(0)), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort.no_stale_valid", 32'(get_ov(0)), 0);
        check("abort.no_stale_rslt", get_r(0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the combinational 9-bit datapath ALU.
- Adds a valid/ready handshake on both sides and registered result/flag.
- Adds iterative bit-serial shifts by a variable amount and a shift-add multiply.
- Sits between the register file read ports and the writeback/branch logic; the controller stalls on in_ready/out_valid.

Parameters:
- WIDTH, 9, datapath width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept an operation
- alu_cmd  input  3  opcode; sampled only on accept
- inA  input  WIDTH  operand A; sampled only on accept
- inB  input  WIDTH  operand B or shift amount; sampled only on accept
- out_valid  output  1  rslt/flag valid
- out_ready  input  1  consumer takes the result
- rslt  output  WIDTH  registered result
- flag  output  1  registered jump/status flag

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; in_ready=1; out_valid=0; rslt=0; flag=0; counter and operand registers 0.
- Reset mid-operation aborts the operation immediately. No result is produced.
- States:
  - IDLE: in_ready=1. Accept occurs when in_valid&in_ready.
    - Single-cycle opcode: go to DONE.
    - Iterative opcode with count k>0: go to BUSY.
    - Iterative opcode with k=0: go to DONE.
  - BUSY: in_ready=0. Perform one iteration per cycle and decrement the counter. When the final iteration completes, go to DONE.
  - DONE: out_valid=1; rslt and flag stay stable. When out_ready=1, go to IDLE.
    - in_ready stays 0 in DONE, so no same-cycle reaccept.
- Latency: accept at edge t.
  - Single-cycle ops: out_valid=1 after edge t+1.
  - Iterative ops: out_valid=1 after edge t+1+k.
  - Minimum issue interval is 2 cycles.
- Inputs are ignored outside IDLE; operands are captured at accept.
- Opcodes (unsigned arithmetic, results mod 2^WIDTH):
  - 000 ADD: rslt=A+B; flag=carry-out.
  - 001 LSL: iterative, k=min(B,WIDTH), shifts 1 bit per cycle.
    - rslt = A<<k.
    - flag = last bit shifted out (A[WIDTH-k]); flag=0 when k=0.
    - B>WIDTH behaves exactly as B=WIDTH: rslt=0, flag=A[0].
  - 010 MUL: shift-add, k=WIDTH.
    - rslt = low WIDTH bits of A*B.
    - flag=1 iff the high WIDTH bits are nonzero (overflow).
  - 011 XOR: rslt=A^B; flag=0.
  - 100 AND: rslt=A&B; flag=0.
  - 101 LSR: iterative, k=min(B,WIDTH); logical shift.
    - rslt = A>>k.
    - flag = last bit shifted out (A[k-1]); flag=0 when k=0.
  - 110 SUB: rslt=A-B; flag=borrow (1 iff A<B).
  - 111 CMP: rslt=A-B; flag=1 iff A==B.
- rslt and flag change only on the transition into DONE (or at reset). They are held through IDLE until the next result.
- out_ready while not in DONE is ignored.
- in_valid held in DONE is not accepted until the state returns to IDLE.

Test Plan:
- Reset and handshake: WIDTH=9, assert rst_n=0 mid-MUL at iteration 4 -> next cycle in_ready=1, out_valid=0, rslt=0, flag=0; no stale result afterwards.
- ADD/SUB/CMP:
  - ADD A=9'h1FF, B=1 -> rslt=0, flag=1, out_valid at t+1.
  - SUB A=3, B=5 -> rslt=9'h1FE, flag=1.
  - CMP A=B=9'h0AA -> rslt=0, flag=1.
- Variable shifts:
  - LSL A=9'h101, B=1 -> rslt=9'h002, flag=1, latency 2.
  - LSR A=9'h003, B=2 -> rslt=0, flag=1, latency 3.
  - LSL B=0 -> rslt=A, flag=0, latency 1.
  - LSL B=20 -> rslt=0, flag=A[0], latency 10.
- MUL:
  - A=12, B=13 -> rslt=156, flag=0, latency 10.
  - A=9'h100, B=2 -> rslt=0, flag=1.
  - A=0, B=anything -> rslt=0, flag=0.
- Backpressure: hold out_ready=0 for 5 cycles after DONE and toggle inA/alu_cmd/in_valid -> rslt, flag and out_valid stable, in_ready=0; release -> IDLE next cycle, then the new op is accepted.
- Width sweep: rerun ADD, LSR and MUL with WIDTH=4 and WIDTH=16 -> results match the golden model mod 2^WIDTH; MUL latency = WIDTH+1.
